// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the screen mappers.
// The generator drives it; every mapper and the sync pins consume it.
interface vga_timing_gen_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        hs_out;
  logic        vs_out;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs,
    output hs_out, vs_out,
    output line_start, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs,
    input hs_out, vs_out,
    input line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running 640x480@60 raster generator with registered decodes
// and hs/vs delay lines matched to the mappers' colour latency.
module vga_timing_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 2
) (
  input  logic              vga_clk,
  input  logic              reset,
  vga_timing_gen_if.master  vif
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_END  = 10'(H_TOT - 1);
  localparam logic [9:0] V_END  = 10'(V_TOT - 1);
  localparam logic [9:0] H_VISL = 10'(H_VIS);
  localparam logic [9:0] V_VISL = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        blank_q, blank_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  // Decodes look at the next counter values so they flip with DrawX/DrawY.
  always_comb begin
    hc_d          = hc_q + 10'd1;
    vc_d          = vc_q;
    frame_count_d = frame_count_q;
    if (hc_q == H_END) begin
      hc_d = '0;
      if (vc_q == V_END) begin
        vc_d          = '0;
        frame_count_d = frame_count_q + 16'd1;
      end else begin
        vc_d = vc_q + 10'd1;
      end
    end
    blank_d       = (hc_d < H_VISL) && (vc_d < V_VISL);
    hs_d          = !((hc_d >= HS_BEG) && (hc_d < HS_END));
    vs_d          = !((vc_d >= VS_BEG) && (vc_d < VS_END));
    line_start_d  = (hc_d == '0);
    frame_start_d = (hc_d == '0) && (vc_d == '0);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q          <= '0;
      vc_q          <= '0;
      frame_count_q <= '0;
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_count_q <= frame_count_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vif.DrawX       = hc_q;
  assign vif.DrawY       = vc_q;
  assign vif.blank       = blank_q;
  assign vif.hs          = hs_q;
  assign vif.vs          = vs_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.frame_count = frame_count_q;

  if (PIPE_DLY == 0) begin : g_nodly
    assign vif.hs_out = hs_q;
    assign vif.vs_out = vs_q;
  end else begin : g_dly
    logic [PIPE_DLY-1:0] hsp_q, hsp_d;
    logic [PIPE_DLY-1:0] vsp_q, vsp_d;

    always_comb begin
      hsp_d    = hsp_q << 1;
      hsp_d[0] = hs_q;
      vsp_d    = vsp_q << 1;
      vsp_d[0] = vs_q;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
        hsp_q <= '1;
        vsp_q <= '1;
      end else begin
        hsp_q <= hsp_d;
        vsp_q <= vsp_d;
      end
    end

    assign vif.hs_out = hsp_q[PIPE_DLY-1];
    assign vif.vs_out = vsp_q[PIPE_DLY-1];
  end

endmodule
